// File: rtl/count_seq_monitor.sv
// Sequence checker for a free-running count bus: locks on the first sample,
// then flags mismatches, warns on prolonged holds and keeps saturating tallies.
module count_seq_monitor #(
    parameter int WIDTH       = 8,
    parameter int STALL_LIMIT = 4,
    parameter int TALLY_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [WIDTH-1:0]   count_in,
    input  logic               clear,
    output logic               locked,
    output logic               err_pulse,
    output logic               warn_pulse,
    output logic [TALLY_W-1:0] err_count,
    output logic [TALLY_W-1:0] warn_count,
    output logic [TALLY_W-1:0] wrap_count,
    output logic [WIDTH-1:0]   last_bad
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_LOCKED   = 2'd1;
    localparam logic [1:0] ST_STALLED  = 2'd2;

    localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ALL_ONES  = '1;
    localparam logic [TALLY_W-1:0] ONE_T     = {{(TALLY_W-1){1'b0}}, 1'b1};
    localparam logic [TALLY_W-1:0] TALLY_MAX = '1;
    localparam logic [7:0]         STALL_LIM = 8'(STALL_LIMIT);

    logic [1:0]         state, state_next;
    logic [WIDTH-1:0]   expected, expected_next;
    logic [WIDTH-1:0]   prev, prev_next;
    logic [7:0]         stall_cnt, stall_next;
    logic               err_next, warn_next, locked_next;
    logic [TALLY_W-1:0] err_cnt_next, warn_cnt_next, wrap_cnt_next;
    logic [WIDTH-1:0]   last_bad_next;
    logic               is_good, is_stall;

    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        return (v == TALLY_MAX) ? v : v + ONE_T;
    endfunction

    assign is_good  = (count_in == expected);
    assign is_stall = (count_in == prev);

    always_comb begin
        state_next    = state;
        expected_next = expected;
        prev_next     = prev;
        stall_next    = stall_cnt;
        err_next      = 1'b0;
        warn_next     = 1'b0;
        err_cnt_next  = err_count;
        warn_cnt_next = warn_count;
        wrap_cnt_next = wrap_count;
        last_bad_next = last_bad;

        if (clear) begin
            state_next    = ST_UNLOCKED;
            expected_next = '0;
            prev_next     = '0;
            stall_next    = '0;
            err_cnt_next  = '0;
            warn_cnt_next = '0;
            wrap_cnt_next = '0;
            last_bad_next = '0;
        end else if (en) begin
            prev_next = count_in;
            case (state)
                ST_UNLOCKED: begin
                    expected_next = count_in + ONE_W;
                    stall_next    = '0;
                    state_next    = ST_LOCKED;
                end
                default: begin
                    // expected is always prev+1, so these three cases never overlap
                    if (is_good) begin
                        expected_next = expected + ONE_W;
                        stall_next    = '0;
                        state_next    = ST_LOCKED;
                        if (prev == ALL_ONES && count_in == '0)
                            wrap_cnt_next = sat_inc(wrap_count);
                    end else if (is_stall) begin
                        if (state != ST_STALLED) begin
                            stall_next = stall_cnt + 8'd1;
                            if (stall_cnt + 8'd1 == STALL_LIM) begin
                                warn_next     = 1'b1;
                                warn_cnt_next = sat_inc(warn_count);
                                state_next    = ST_STALLED;
                            end
                        end
                    end else begin
                        err_next      = 1'b1;
                        err_cnt_next  = sat_inc(err_count);
                        last_bad_next = count_in;
                        expected_next = count_in + ONE_W;
                        stall_next    = '0;
                        state_next    = ST_LOCKED;
                    end
                end
            endcase
        end
    end

    assign locked_next = (state_next != ST_UNLOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_UNLOCKED;
            expected   <= '0;
            prev       <= '0;
            stall_cnt  <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            warn_pulse <= 1'b0;
            err_count  <= '0;
            warn_count <= '0;
            wrap_count <= '0;
            last_bad   <= '0;
        end else begin
            state      <= state_next;
            expected   <= expected_next;
            prev       <= prev_next;
            stall_cnt  <= stall_next;
            locked     <= locked_next;
            err_pulse  <= err_next;
            warn_pulse <= warn_next;
            err_count  <= err_cnt_next;
            warn_count <= warn_cnt_next;
            wrap_count <= wrap_cnt_next;
            last_bad   <= last_bad_next;
        end
    end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Self-checking bench for count_seq_monitor: vector table, directed corner
// sequences and random stimulus against a sample-history reference model.
module tb_count_seq_monitor;

    localparam int WIDTH       = 8;
    localparam int STALL_LIMIT = 4;
    localparam int TALLY_W     = 4;
    localparam int MASK        = (1 << WIDTH) - 1;
    localparam int TMAX        = (1 << TALLY_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic [WIDTH-1:0]   count_in;
    logic               clear;
    logic               locked;
    logic               err_pulse;
    logic               warn_pulse;
    logic [TALLY_W-1:0] err_count;
    logic [TALLY_W-1:0] warn_count;
    logic [TALLY_W-1:0] wrap_count;
    logic [WIDTH-1:0]   last_bad;

    count_seq_monitor #(
        .WIDTH(WIDTH), .STALL_LIMIT(STALL_LIMIT), .TALLY_W(TALLY_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .count_in(count_in), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .warn_pulse(warn_pulse),
        .err_count(err_count), .warn_count(warn_count), .wrap_count(wrap_count),
        .last_bad(last_bad)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remembers the last accepted sample and the length of
    // the current run of repeats; no notion of an "expected" register.
    bit m_have;
    int m_prev, m_rep, m_err, m_warn, m_wrap, m_last_bad;
    bit m_err_p, m_warn_p;

    task automatic model_reset();
        m_have = 0; m_prev = 0; m_rep = 0;
        m_err = 0; m_warn = 0; m_wrap = 0; m_last_bad = 0;
        m_err_p = 0; m_warn_p = 0;
    endtask

    function automatic int sat(input int v);
        return (v >= TMAX) ? TMAX : v + 1;
    endfunction

    task automatic model_step(input bit e, input bit c, input int v);
        m_err_p = 0; m_warn_p = 0;
        if (c) begin
            model_reset();
        end else if (e) begin
            if (!m_have) begin
                m_have = 1; m_rep = 0;
            end else if (v == ((m_prev + 1) & MASK)) begin
                if (m_prev == MASK) m_wrap = sat(m_wrap);
                m_rep = 0;
            end else if (v == m_prev) begin
                m_rep++;
                if (m_rep == STALL_LIMIT) begin
                    m_warn_p = 1;
                    m_warn   = sat(m_warn);
                end
            end else begin
                m_err_p = 1;
                m_err   = sat(m_err);
                m_last_bad = v;
                m_rep   = 0;
            end
            m_prev = v;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".locked"},     32'(locked),     32'(m_have));
        chk({tag, ".err_pulse"},  32'(err_pulse),  32'(m_err_p));
        chk({tag, ".warn_pulse"}, 32'(warn_pulse), 32'(m_warn_p));
        chk({tag, ".err_count"},  32'(err_count),  32'(m_err));
        chk({tag, ".warn_count"}, 32'(warn_count), 32'(m_warn));
        chk({tag, ".wrap_count"}, 32'(wrap_count), 32'(m_wrap));
        chk({tag, ".last_bad"},   32'(last_bad),   32'(m_last_bad));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".locked"},     32'(locked),     0);
        chk({tag, ".err_pulse"},  32'(err_pulse),  0);
        chk({tag, ".warn_pulse"}, 32'(warn_pulse), 0);
        chk({tag, ".err_count"},  32'(err_count),  0);
        chk({tag, ".warn_count"}, 32'(warn_count), 0);
        chk({tag, ".wrap_count"}, 32'(wrap_count), 0);
        chk({tag, ".last_bad"},   32'(last_bad),   0);
    endtask

    task automatic step(input bit e, input bit c, input logic [WIDTH-1:0] v, input string tag);
        en = e; clear = c; count_in = v;
        @(posedge clk);
        #1;
        model_step(e, c, int'(v));
        check_model(tag);
        $display("%s en=%0b clr=%0b in=%02h -> lock=%0b err=%0b warn=%0b ec=%0d wc=%0d wr=%0d lb=%02h",
                 tag, e, c, v, locked, err_pulse, warn_pulse, err_count, warn_count,
                 wrap_count, last_bad);
    endtask

    typedef struct {
        bit             en;
        bit             clr;
        logic [7:0]     cin;
        bit             e_locked;
        bit             e_err;
        bit             e_warn;
    } vec_t;

    vec_t tbl[24];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] drv;
        int hold_left;
        int r;
        bit e, c;
        logic [WIDTH-1:0] v;

        tbl[0]  = '{1, 0, 8'h05, 1, 0, 0};
        tbl[1]  = '{1, 0, 8'h06, 1, 0, 0};
        tbl[2]  = '{1, 0, 8'h07, 1, 0, 0};
        tbl[3]  = '{1, 0, 8'h20, 1, 1, 0};
        tbl[4]  = '{1, 0, 8'h21, 1, 0, 0};
        tbl[5]  = '{0, 0, 8'h55, 1, 0, 0};
        tbl[6]  = '{1, 0, 8'h22, 1, 0, 0};
        tbl[7]  = '{1, 1, 8'h99, 0, 0, 0};
        tbl[8]  = '{1, 0, 8'h03, 1, 0, 0};
        tbl[9]  = '{1, 0, 8'h03, 1, 0, 0};
        tbl[10] = '{1, 0, 8'h03, 1, 0, 0};
        tbl[11] = '{1, 0, 8'h03, 1, 0, 0};
        tbl[12] = '{1, 0, 8'h03, 1, 0, 1};
        tbl[13] = '{1, 0, 8'h03, 1, 0, 0};
        tbl[14] = '{1, 0, 8'h03, 1, 0, 0};
        tbl[15] = '{1, 0, 8'h04, 1, 0, 0};
        tbl[16] = '{1, 0, 8'h09, 1, 1, 0};
        tbl[17] = '{1, 0, 8'h09, 1, 0, 0};
        tbl[18] = '{1, 1, 8'h00, 0, 0, 0};
        tbl[19] = '{1, 0, 8'hFD, 1, 0, 0};
        tbl[20] = '{1, 0, 8'hFE, 1, 0, 0};
        tbl[21] = '{1, 0, 8'hFF, 1, 0, 0};
        tbl[22] = '{1, 0, 8'h00, 1, 0, 0};
        tbl[23] = '{1, 0, 8'h01, 1, 0, 0};

        rst_n = 1'b0; en = 1'b0; clear = 1'b0; count_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].cin, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.vec_locked", i), 32'(locked),     32'(tbl[i].e_locked));
            chk($sformatf("tbl%0d.vec_err", i),    32'(err_pulse),  32'(tbl[i].e_err));
            chk($sformatf("tbl%0d.vec_warn", i),   32'(warn_pulse), 32'(tbl[i].e_warn));
        end
        chk("wrap_after_table", 32'(wrap_count), 1);
        chk("err_after_wrap",   32'(err_count),  0);

        // Plain ramp 0..9
        step(1, 1, 8'h00, "ramp_clr");
        for (int i = 0; i < 10; i++) step(1, 0, 8'(i), $sformatf("ramp%0d", i));
        chk("ramp_err",  32'(err_count),  0);
        chk("ramp_warn", 32'(warn_count), 0);
        chk("ramp_wrap", 32'(wrap_count), 0);

        // en toggling with count held during the gaps
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 8'(10 + i), $sformatf("gap_on%0d", i));
            step(0, 0, 8'(10 + i), $sformatf("gap_off%0d", i));
        end
        chk("gap_err",  32'(err_count),  0);
        chk("gap_warn", 32'(warn_count), 0);

        // Back-to-back mismatches up to and beyond tally saturation
        step(1, 1, 8'h00, "sat_clr");
        step(1, 0, 8'h00, "sat_lock");
        for (int i = 0; i < 20; i++) begin
            step(1, 0, (i % 2 == 0) ? 8'h80 : 8'h00, $sformatf("sat%0d", i));
            chk($sformatf("sat%0d.pulse", i), 32'(err_pulse), 1);
        end
        chk("sat_err_count", 32'(err_count), TMAX);

        // Random stimulus
        step(1, 1, 8'h00, "rnd_clr");
        drv = 8'h00; hold_left = 0;
        for (int i = 0; i < 1500; i++) begin
            e = ($urandom % 4) != 0;
            c = ($urandom % 100) == 0;
            if (hold_left > 0) begin
                hold_left--;
                v = drv;
            end else begin
                r = $urandom % 20;
                if (r == 0) v = 8'($urandom);
                else if (r == 1) begin
                    hold_left = $urandom_range(1, 6);
                    v = drv;
                end else v = drv + 8'd1;
            end
            step(e, c, v, $sformatf("rnd%0d", i));
            if (e) drv = v;
        end

        // Asynchronous reset mid-stream, between clock edges
        step(1, 0, 8'h30, "pre_rst0");
        step(1, 0, 8'h77, "pre_rst1");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("rst_held");
        rst_n = 1'b1;
        step(1, 0, 8'h42, "post_rst0");
        step(1, 0, 8'h43, "post_rst1");
        step(1, 0, 8'h50, "post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
